// File: rtl/dbg_bridge_mux_if.sv
// Host and target debug pin bundle for dbg_bridge_mux.
// The bridge uses the master modport; the host and target models use the slave modport.
interface dbg_bridge_mux_if #(
  parameter int NUM_TGT = 2
) ();
  logic               host_p0;
  logic               host_p1;
  logic               host_p2;
  logic               host_p3;
  logic [NUM_TGT-1:0] tgt_tck;
  logic [NUM_TGT-1:0] tgt_tdi;
  logic [NUM_TGT-1:0] tgt_tms;
  logic [NUM_TGT-1:0] tgt_tdo;
  logic [NUM_TGT-1:0] tgt_urx;
  logic [NUM_TGT-1:0] tgt_utx;

  modport master (
    input  host_p0, host_p1, host_p2, tgt_tdo, tgt_utx,
    output host_p3, tgt_tck, tgt_tdi, tgt_tms, tgt_urx
  );

  modport slave (
    output host_p0, host_p1, host_p2, tgt_tdo, tgt_utx,
    input  host_p3, tgt_tck, tgt_tdi, tgt_tms, tgt_urx
  );
endinterface

// File: rtl/dbg_bridge_mux.sv
// Routes one shared JTAG/UART host debug port to one of NUM_TGT targets.
// Mode comes from a debounced jumper; target switches wait for an idle host link.
module dbg_bridge_mux #(
  parameter int NUM_TGT     = 2,
  parameter int SEL_W       = 3,
  parameter int DEB_CYCLES  = 65536,
  parameter int IDLE_CYCLES = 256,
  parameter int STRETCH_W   = 20,
  parameter int PWM_BITS    = 4,
  parameter int PWM_DUTY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dbg_bridge_mux_if.master bus,
  input  logic [SEL_W-1:0] tgt_sel,
  output logic             jmp_drive,
  input  logic             jmp_sense,
  output logic             mode,
  output logic [SEL_W-1:0] act_sel,
  output logic             led_pwm_g,
  output logic             led_pwm_b,
  output logic             led_pwm_r
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [SEL_W:0]    NUM_TGT_L  = (SEL_W+1)'(NUM_TGT);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [PWM_BITS:0] PWM_DUTY_L = (PWM_BITS+1)'(PWM_DUTY);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } sel_state_t;

  logic                 p0_s1_r, p0_s2_r, p0_s3_r;
  logic                 jmp_s1_r, jmp_s2_r;
  logic [SEL_W-1:0]     sel_s1_r, sel_s2_r;
  logic                 mode_r;
  logic [DEB_W-1:0]     deb_cnt_r;
  sel_state_t           state_r, state_nx_s;
  logic [IDLE_W-1:0]    idle_cnt_r, idle_nx_s;
  logic [SEL_W-1:0]     act_sel_r, act_nx_s;
  logic                 sel_err_r;
  logic [STRETCH_W-1:0] stretch_r;
  logic [PWM_BITS-1:0]  pwm_cnt_r;
  logic                 led_g_r, led_b_r, led_r_r;
  logic                 p0_edge_s;
  logic                 sel_valid_s;
  logic                 led_on_s;
  logic                 host_p3_s;
  logic [NUM_TGT-1:0]   tck_s, tdi_s, tms_s, urx_s;

  assign p0_edge_s   = p0_s2_r ^ p0_s3_r;
  assign sel_valid_s = ({1'b0, sel_s2_r} < NUM_TGT_L);
  assign led_on_s    = ({1'b0, pwm_cnt_r} < PWM_DUTY_L);

  // Two-flop synchronisers plus one extra host_p0 stage for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0_s1_r  <= 1'b0;
      p0_s2_r  <= 1'b0;
      p0_s3_r  <= 1'b0;
      jmp_s1_r <= 1'b1;
      jmp_s2_r <= 1'b1;
      sel_s1_r <= '0;
      sel_s2_r <= '0;
    end else begin
      p0_s1_r  <= bus.host_p0;
      p0_s2_r  <= p0_s1_r;
      p0_s3_r  <= p0_s2_r;
      jmp_s1_r <= jmp_sense;
      jmp_s2_r <= jmp_s1_r;
      sel_s1_r <= tgt_sel;
      sel_s2_r <= sel_s1_r;
    end
  end

  // Jumper debounce: sense low means UART, so agreement is sense == ~mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r    <= 1'b0;
      deb_cnt_r <= '0;
    end else if (jmp_s2_r == ~mode_r) begin
      mode_r    <= mode_r;
      deb_cnt_r <= '0;
    end else if (deb_cnt_r == DEB_LAST) begin
      mode_r    <= ~mode_r;
      deb_cnt_r <= '0;
    end else begin
      mode_r    <= mode_r;
      deb_cnt_r <= deb_cnt_r + DEB_W'(1);
    end
  end

  // Select FSM next state: a change is only applied after the host link has been quiet.
  always_comb begin
    state_nx_s = state_r;
    idle_nx_s  = idle_cnt_r;
    act_nx_s   = act_sel_r;
    case (state_r)
      ST_RUN: begin
        if (sel_valid_s && (sel_s2_r != act_sel_r)) begin
          state_nx_s = ST_DRAIN;
          idle_nx_s  = '0;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!sel_valid_s || (sel_s2_r == act_sel_r)) begin
          state_nx_s = ST_RUN;
        end else if (p0_edge_s) begin
          idle_nx_s = '0;
        end else if (idle_cnt_r == IDLE_LAST) begin
          state_nx_s = ST_SWITCH;
        end else begin
          idle_nx_s = idle_cnt_r + IDLE_W'(1);
        end
      end
      ST_SWITCH: begin
        state_nx_s = ST_RUN;
        if (sel_valid_s) begin
          act_nx_s = sel_s2_r;
        end else begin
          act_nx_s = act_sel_r;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
  end

  // Select FSM state, idle counter, applied target and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      idle_cnt_r <= '0;
      act_sel_r  <= '0;
      sel_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      idle_cnt_r <= idle_nx_s;
      act_sel_r  <= act_nx_s;
      sel_err_r  <= ~sel_valid_s;
    end
  end

  // Activity stretcher, free-running PWM phase and registered LED drives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stretch_r <= '0;
      pwm_cnt_r <= '0;
      led_g_r   <= 1'b0;
      led_b_r   <= 1'b0;
      led_r_r   <= 1'b0;
    end else begin
      if (p0_edge_s) begin
        stretch_r <= '1;
      end else if (stretch_r != '0) begin
        stretch_r <= stretch_r - STRETCH_W'(1);
      end else begin
        stretch_r <= '0;
      end
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      led_g_r   <= led_on_s & (stretch_r != '0) & ~mode_r;
      led_b_r   <= led_on_s & (stretch_r != '0) & mode_r;
      led_r_r   <= led_on_s & ((state_r == ST_DRAIN) | sel_err_r);
    end
  end

  // Combinational pin routing: TCK is asynchronous to clk, idle level everywhere is 1.
  always_comb begin
    host_p3_s = 1'b1;
    tck_s     = '1;
    tdi_s     = '1;
    tms_s     = '1;
    urx_s     = '1;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (act_sel_r == SEL_W'(k)) begin
        if (mode_r) begin
          urx_s[k]  = bus.host_p0;
          host_p3_s = bus.tgt_utx[k];
        end else begin
          tck_s[k]  = bus.host_p0;
          tdi_s[k]  = bus.host_p1;
          tms_s[k]  = bus.host_p2;
          host_p3_s = bus.tgt_tdo[k];
        end
      end else begin
        urx_s[k] = 1'b1;
      end
    end
  end

  assign bus.host_p3 = host_p3_s;
  assign bus.tgt_tck = tck_s;
  assign bus.tgt_tdi = tdi_s;
  assign bus.tgt_tms = tms_s;
  assign bus.tgt_urx = urx_s;
  assign jmp_drive   = 1'b0;
  assign mode        = mode_r;
  assign act_sel     = act_sel_r;
  assign led_pwm_g   = led_g_r;
  assign led_pwm_b   = led_b_r;
  assign led_pwm_r   = led_r_r;

endmodule
